pipe_decode_execute: RTL

//  Decode->execute pipeline register. Drives the execute stage's operand and ALU-control inputs.

---
 rtl/pipe_decode_execute_pkg.sv | 21 ++
 rtl/fwd_select.sv | 30 +++
 rtl/pipe_decode_execute.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pipe_decode_execute_pkg.sv
// rtl/pipe_decode_execute_pkg.sv - shared ALU/source encodings and register-update selector
package pipe_decode_execute_pkg;

  localparam logic [1:0] ALU_OP_ADD  = 2'd0;
  localparam logic [1:0] ALU_OP_SUB  = 2'd1;
  localparam logic [1:0] ALU_OP_OR   = 2'd2;
  localparam logic [1:0] ALU_OP_SL16 = 2'd3;

  localparam logic ALU_SRC1_RT  = 1'b0;
  localparam logic ALU_SRC1_IMM = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    UPD_RESET,
    UPD_FLUSH,
    UPD_STALL,
    UPD_LOAD
  } upd_e;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - one operand forwarding mux; M beats W, register 0 always reads 0
module fwd_select
  import pipe_decode_execute_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic [REG_W-1:0]  addr,
  input  logic [DATA_W-1:0] q,
  input  logic              m_wr_en,
  input  logic [REG_W-1:0]  m_wr_addr,
  input  logic [DATA_W-1:0] m_wr_data,
  input  logic              w_wr_en,
  input  logic [REG_W-1:0]  w_wr_addr,
  input  logic [DATA_W-1:0] w_wr_data,
  output logic [DATA_W-1:0] out
);

  always_comb begin
    out = q;
    if (addr == REG_W'(REG_ZERO)) begin
      out = '0;
    end else if (m_wr_en && (m_wr_addr == addr)) begin
      out = m_wr_data;
    end else if (w_wr_en && (w_wr_addr == addr)) begin
      out = w_wr_data;
    end
  end

endmodule

// File: rtl/pipe_decode_execute.sv
// rtl/pipe_decode_execute.sv - decode->execute pipeline register with stall, flush and operand forwarding
module pipe_decode_execute
  import pipe_decode_execute_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int OP_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              d_valid,
  input  logic [DATA_W-1:0] d_pc,
  input  logic [REG_W-1:0]  d_rs_addr,
  input  logic [REG_W-1:0]  d_rt_addr,
  input  logic [DATA_W-1:0] d_rs_data,
  input  logic [DATA_W-1:0] d_rt_data,
  input  logic              d_alu_src1,
  input  logic [OP_W-1:0]   d_alu_op,
  input  logic [DATA_W-1:0] d_ext_imm,
  input  logic              d_wr_en,
  input  logic [REG_W-1:0]  d_wr_addr,
  input  logic              m_wr_en,
  input  logic [REG_W-1:0]  m_wr_addr,
  input  logic [DATA_W-1:0] m_wr_data,
  input  logic              w_wr_en,
  input  logic [REG_W-1:0]  w_wr_addr,
  input  logic [DATA_W-1:0] w_wr_data,
  output logic              e_valid,
  output logic [DATA_W-1:0] e_pc,
  output logic [DATA_W-1:0] e_grf_in0,
  output logic [DATA_W-1:0] e_grf_in1,
  output logic              e_alu_src1,
  output logic [OP_W-1:0]   e_alu_op,
  output logic [DATA_W-1:0] e_ext_imm,
  output logic              e_wr_en,
  output logic [REG_W-1:0]  e_wr_addr,
  output logic [REG_W-1:0]  e_rs_addr,
  output logic [REG_W-1:0]  e_rt_addr,
  output logic [15:0]       bubble_cnt
);

  logic [DATA_W-1:0] rs_q;
  logic [DATA_W-1:0] rt_q;
  upd_e              upd;

  fwd_select #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
    .addr      (e_rs_addr),
    .q         (rs_q),
    .m_wr_en   (m_wr_en),
    .m_wr_addr (m_wr_addr),
    .m_wr_data (m_wr_data),
    .w_wr_en   (w_wr_en),
    .w_wr_addr (w_wr_addr),
    .w_wr_data (w_wr_data),
    .out       (e_grf_in0)
  );

  fwd_select #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
    .addr      (e_rt_addr),
    .q         (rt_q),
    .m_wr_en   (m_wr_en),
    .m_wr_addr (m_wr_addr),
    .m_wr_data (m_wr_data),
    .w_wr_en   (w_wr_en),
    .w_wr_addr (w_wr_addr),
    .w_wr_data (w_wr_data),
    .out       (e_grf_in1)
  );

  always_comb begin
    upd = UPD_LOAD;
    if (reset) begin
      upd = UPD_RESET;
    end else if (flush) begin
      upd = UPD_FLUSH;
    end else if (stall) begin
      upd = UPD_STALL;
    end
  end

  // Reset and flush both leave an all-zero bubble; only flush is counted.
  always_ff @(posedge clk) begin
    case (upd)
      UPD_RESET, UPD_FLUSH: begin
        e_valid    <= 1'b0;
        e_pc       <= '0;
        e_rs_addr  <= '0;
        e_rt_addr  <= '0;
        rs_q       <= '0;
        rt_q       <= '0;
        e_alu_src1 <= 1'b0;
        e_alu_op   <= '0;
        e_ext_imm  <= '0;
        e_wr_en    <= 1'b0;
        e_wr_addr  <= '0;
      end
      UPD_STALL: begin
        // A producer visible now may retire before the stall releases.
        rs_q <= e_grf_in0;
        rt_q <= e_grf_in1;
      end
      default: begin
        e_valid    <= d_valid;
        e_pc       <= d_pc;
        e_rs_addr  <= d_rs_addr;
        e_rt_addr  <= d_rt_addr;
        rs_q       <= d_rs_data;
        rt_q       <= d_rt_data;
        e_alu_src1 <= d_alu_src1;
        e_alu_op   <= d_alu_op;
        e_ext_imm  <= d_ext_imm;
        e_wr_en    <= d_wr_en & d_valid;
        e_wr_addr  <= d_wr_addr;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (upd == UPD_RESET) begin
      bubble_cnt <= '0;
    end else if (upd == UPD_FLUSH) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

endmodule
